// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises CPU read/write requests onto a single-port memory.
// Requests may use direct or one-level indirect addressing.
// Build option: define MEM_INDIRECT_EN to include the IND state and pointer resolution.
// Without it, req_ind is ignored and every access is direct.
module mem_access_ctrl #(
    parameter int ADR_W  = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_ind,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADR_W-1:0]  rsp_ea,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_INDIRECT_EN
    typedef enum logic [1:0] {IDLE, IND, ACC, RSP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;
`endif

    state_t             state, state_nx;
    logic               we_r;
    logic [ADR_W-1:0]   adr_r;
    logic [ADR_W-1:0]   ea_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               accept;

`ifndef MEM_INDIRECT_EN
    logic unused_ind;
    assign unused_ind = req_ind;
`endif

    assign accept = (state == IDLE) && req_valid;

    // State register; reset returns to IDLE immediately so strobes drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state sequencing: optional pointer fetch, one access cycle, one response cycle.
    always_comb begin
        state_nx = state;
        case (state)
`ifdef MEM_INDIRECT_EN
            IDLE:    state_nx = accept ? (req_ind ? IND : ACC) : IDLE;
            IND:     state_nx = ACC;
`else
            IDLE:    state_nx = accept ? ACC : IDLE;
`endif
            ACC:     state_nx = RSP;
            RSP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode only from state and registered request fields, never from req_*.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RSP);
        rsp_ea    = (state == RSP) ? ea_r : '0;
        mem_write = (state == ACC) && we_r;
`ifdef MEM_INDIRECT_EN
        mem_read  = ((state == ACC) && !we_r) || (state == IND);
        mem_adr   = (state == IND) ? adr_r : ((state == ACC) ? ea_r : '0);
`else
        mem_read  = (state == ACC) && !we_r;
        mem_adr   = (state == ACC) ? ea_r : '0;
`endif
        mem_wdata = mem_write ? wdata_r : '0;
    end

    // Request capture, effective-address resolution and read-data hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r      <= 1'b0;
            adr_r     <= '0;
            wdata_r   <= '0;
            ea_r      <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                we_r    <= req_we;
                adr_r   <= req_adr;
                wdata_r <= req_wdata;
                ea_r    <= req_adr;
            end
`ifdef MEM_INDIRECT_EN
            if (state == IND)
                ea_r <= mem_rdata[ADR_W-1:0];
`endif
            if ((state == ACC) && !we_r)
                rsp_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed bench with a transaction-level reference model.
module tb_mem_access_ctrl;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic          req_ind = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_ea;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] env_mem [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    mem_access_ctrl #(.ADR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_ind(req_ind),
        .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ea(rsp_ea),
        .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: combinational read, write on rising edge.
    assign mem_rdata = env_mem[mem_adr];
    always @(posedge clk) if (mem_write) env_mem[mem_adr] <= mem_wdata;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    bit            pend = 0;
    bit            p_we = 0;
    logic [AW-1:0] p_ea = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [DW-1:0] p_rdata = '0;
    logic [DW-1:0] last_rdata = '0;
    int            p_resp = 0;
    int            last_acc = -1;
    int            prev_acc = -1;
    int            n_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, outcome computed at acceptance.
    always @(posedge clk) if (rst_n) begin
        bit            acc;
        int            lat;
        logic [AW-1:0] ea;
        acc = req_valid && !pend;
        if (pend && cyc == p_resp) pend = 0;
        if (acc) begin
            ea  = req_adr;
            lat = 2;
`ifdef MEM_INDIRECT_EN
            if (req_ind) begin
                ea  = ref_mem[req_adr][AW-1:0];
                lat = 3;
            end
`endif
            pend     = 1;
            p_we     = req_we;
            p_ea     = ea;
            p_wdata  = req_wdata;
            p_rdata  = ref_mem[ea];
            p_resp   = cyc + lat;
            prev_acc = last_acc;
            last_acc = cyc;
            n_acc++;
        end
        cyc++;
        if (pend && cyc == p_resp) begin
            if (p_we) ref_mem[p_ea] = p_wdata;
            else last_rdata = p_rdata;
        end
    end

    always @(negedge rst_n) begin
        pend       = 0;
        last_rdata = '0;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) if (rst_n) begin
        bit act_c;
        bit wr_c;
        act_c = pend && cyc < p_resp;
        wr_c  = pend && p_we && cyc == p_resp - 1;
        check("req_ready", req_ready, !pend);
        check("rsp_valid", rsp_valid, pend && cyc == p_resp);
        check("mem_write", mem_write, wr_c);
        check("mem_read", mem_read, act_c && !wr_c);
        check("rsp_rdata", rsp_rdata, last_rdata);
        if (pend && cyc == p_resp) check("rsp_ea", rsp_ea, p_ea);
        if (wr_c) begin
            check("mem_adr", mem_adr, p_ea);
            check("mem_wdata", mem_wdata, p_wdata);
        end
    end

    // Start and end at a negedge; holds the request until accepted, then scrambles inputs.
    task automatic do_req(input bit we, input bit ind, input logic [AW-1:0] adr, input logic [DW-1:0] wd);
        int start;
        int k;
        req_valid = 1; req_we = we; req_ind = ind; req_adr = adr; req_wdata = wd;
        start = n_acc;
        k = 0;
        while (n_acc == start && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (n_acc == start) check("accept_timeout", 0, 1);
        req_valid = 0;
        req_we    = 1'($urandom);
        req_ind   = 1'($urandom);
        req_adr   = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic wait_rsp(input int lat, input logic [DW-1:0] rd, input logic [AW-1:0] ea);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("rsp_seen", rsp_valid, 1);
        check("latency", cyc - last_acc, lat);
        check("lit_rdata", rsp_rdata, rd);
        check("lit_ea", rsp_ea, ea);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_mem_read"}, mem_read, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_adr"}, mem_adr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_ea"}, rsp_ea, 0);
    endtask

    logic [DW-1:0] prior;
    int            base;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = DW'($urandom);
            env_mem[i] = ref_mem[i];
        end
        ref_mem[12'h0C8] = 16'h1100; env_mem[12'h0C8] = 16'h1100;
        ref_mem[12'h0CA] = 16'h012C; env_mem[12'h0CA] = 16'h012C;
        ref_mem[12'h12C] = 16'h1110; env_mem[12'h12C] = 16'h1110;
        ref_mem[12'h190] = 16'h0F0F; env_mem[12'h190] = 16'h0F0F;
        ref_mem[12'h200] = 16'hF123; env_mem[12'h200] = 16'hF123;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1;
        base = cyc;
        do_req(0, 0, 12'h0C8, 16'h0);
        check("first_accept_edge", last_acc, base);
        wait_rsp(2, 16'h1100, 12'h0C8);
        do_req(0, 1, 12'h0CA, 16'h0);
`ifdef MEM_INDIRECT_EN
        wait_rsp(3, 16'h1110, 12'h12C);
        prior = 16'h1110;
        do_req(0, 1, 12'h200, 16'h0);
        wait_rsp(3, ref_mem[12'h123], 12'h123);
        prior = ref_mem[12'h123];
`else
        wait_rsp(2, 16'h012C, 12'h0CA);
        prior = 16'h012C;
`endif
        do_req(1, 0, 12'h190, 16'hABCD);
        wait_rsp(2, prior, 12'h190);
        do_req(0, 0, 12'h190, 16'h0);
        wait_rsp(2, 16'hABCD, 12'h190);
        req_valid = 1; req_we = 0; req_ind = 0; req_adr = 12'h0C8;
        base = n_acc;
        for (int k = 0; k < 20 && n_acc < base + 2; k++) @(negedge clk);
        req_valid = 0;
        check("b2b_accepts", n_acc - base, 2);
        check("b2b_interval", last_acc - prev_acc, 3);
        wait_rsp(2, 16'h1100, 12'h0C8);
        do_req(1, 0, 12'h190, 16'h5555);
        check("acc_write_strobe", mem_write, 1);
        rst_n = 0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(negedge clk);
        check_reset_outputs("held");
        check("mem_190_kept", env_mem[12'h190], 16'hABCD);
        rst_n = 1;
        base = cyc;
        do_req(0, 0, 12'h190, 16'h0);
        check("rearm_accept_edge", last_acc, base);
        wait_rsp(2, 16'hABCD, 12'h190);
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom), 1'($urandom),
                   ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom),
                   DW'($urandom));
        end
        repeat (6) @(negedge clk);
        check("final_mem_190", env_mem[12'h190], ref_mem[12'h190]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
